// File: rtl/id_alu_decoder.sv
// ID/EX pipeline register with RV32I decode into the execute-stage ALU control word.
// Outputs are registered: an instruction sampled on one rising edge drives the
// control word for the following cycle. Hazard-unit controls: STALL holds, FLUSH bubbles.
module id_alu_decoder #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     INSTR_IN,
    input  logic [DATA_WIDTH-1:0]     PC_IN,
    input  logic                      INSTR_VALID_IN,
    input  logic                      STALL,
    input  logic                      FLUSH,
    output logic [4:0]                ALU_INSTRUCTION,
    output logic [DATA_WIDTH-1:0]     IMM_OUT,
    output logic [1:0]                OP1_SEL,
    output logic                      OP2_SEL_IMM,
    output logic [REG_ADDR_WIDTH-1:0] RS1_ADDR,
    output logic [REG_ADDR_WIDTH-1:0] RS2_ADDR,
    output logic [REG_ADDR_WIDTH-1:0] RD_ADDR,
    output logic                      REG_WRITE_EN,
    output logic                      MEM_READ,
    output logic                      MEM_WRITE,
    output logic [DATA_WIDTH-1:0]     PC_OUT,
    output logic                      VALID_OUT,
    output logic                      ILLEGAL_INSTR
);

    localparam logic [4:0] AluNop  = 5'd0;
    localparam logic [4:0] AluAdd  = 5'd1;
    localparam logic [4:0] AluSub  = 5'd2;
    localparam logic [4:0] AluSll  = 5'd3;
    localparam logic [4:0] AluSlt  = 5'd4;
    localparam logic [4:0] AluSltu = 5'd5;
    localparam logic [4:0] AluXor  = 5'd6;
    localparam logic [4:0] AluSrl  = 5'd7;
    localparam logic [4:0] AluSra  = 5'd8;
    localparam logic [4:0] AluOr   = 5'd9;
    localparam logic [4:0] AluAnd  = 5'd10;
    localparam logic [4:0] AluSlli = 5'd11;
    localparam logic [4:0] AluSrli = 5'd12;
    localparam logic [4:0] AluSrai = 5'd13;
    localparam logic [4:0] AluJal  = 5'd14;
    localparam logic [4:0] AluJalr = 5'd15;
    localparam logic [4:0] AluBeq  = 5'd16;
    localparam logic [4:0] AluBne  = 5'd17;
    localparam logic [4:0] AluBlt  = 5'd18;
    localparam logic [4:0] AluBge  = 5'd19;
    localparam logic [4:0] AluBltu = 5'd20;
    localparam logic [4:0] AluBgeu = 5'd21;

    localparam logic [1:0] Op1Rs1  = 2'd0;
    localparam logic [1:0] Op1Pc   = 2'd1;
    localparam logic [1:0] Op1Zero = 2'd2;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [4:0]  alu_d;
    logic [31:0] imm_d;
    logic [1:0]  op1_d;
    logic        op2_imm_d;
    logic        reg_write_d;
    logic        mem_read_d;
    logic        mem_write_d;
    logic        illegal_d;
    logic        bubble;

    assign instr  = INSTR_IN[31:0];
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Decode the incoming instruction into the next control word.
    always_comb begin
        alu_d       = AluNop;
        imm_d       = '0;
        op1_d       = Op1Rs1;
        op2_imm_d   = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        illegal_d   = 1'b0;

        case (opcode)
            7'b0110011: begin
                reg_write_d = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7Zero)     alu_d = AluAdd;
                        else if (funct7 == F7Alt) alu_d = AluSub;
                        else                      illegal_d = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7Zero)     alu_d = AluSrl;
                        else if (funct7 == F7Alt) alu_d = AluSra;
                        else                      illegal_d = 1'b1;
                    end
                    default: begin
                        if (funct7 != F7Zero) illegal_d = 1'b1;
                        case (funct3)
                            3'b001:  alu_d = AluSll;
                            3'b010:  alu_d = AluSlt;
                            3'b011:  alu_d = AluSltu;
                            3'b100:  alu_d = AluXor;
                            3'b110:  alu_d = AluOr;
                            default: alu_d = AluAnd;
                        endcase
                    end
                endcase
            end
            7'b0010011: begin
                reg_write_d = 1'b1;
                op2_imm_d   = 1'b1;
                imm_d       = imm_i;
                case (funct3)
                    3'b000: alu_d = AluAdd;
                    3'b010: alu_d = AluSlt;
                    3'b011: alu_d = AluSltu;
                    3'b100: alu_d = AluXor;
                    3'b110: alu_d = AluOr;
                    3'b111: alu_d = AluAnd;
                    3'b001: begin
                        if (funct7 == F7Zero) alu_d = AluSlli;
                        else                  illegal_d = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7Zero)     alu_d = AluSrli;
                        else if (funct7 == F7Alt) alu_d = AluSrai;
                        else                      illegal_d = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin
                alu_d       = AluAdd;
                op1_d       = Op1Zero;
                op2_imm_d   = 1'b1;
                imm_d       = imm_u;
                reg_write_d = 1'b1;
            end
            7'b0010111: begin
                alu_d       = AluAdd;
                op1_d       = Op1Pc;
                op2_imm_d   = 1'b1;
                imm_d       = imm_u;
                reg_write_d = 1'b1;
            end
            7'b1101111: begin
                alu_d       = AluJal;
                op1_d       = Op1Pc;
                op2_imm_d   = 1'b1;
                imm_d       = imm_j;
                reg_write_d = 1'b1;
            end
            7'b1100111: begin
                alu_d       = AluJalr;
                op2_imm_d   = 1'b1;
                imm_d       = imm_i;
                reg_write_d = 1'b1;
                if (funct3 != 3'b000) illegal_d = 1'b1;
            end
            7'b1100011: begin
                imm_d = imm_b;
                case (funct3)
                    3'b000:  alu_d = AluBeq;
                    3'b001:  alu_d = AluBne;
                    3'b100:  alu_d = AluBlt;
                    3'b101:  alu_d = AluBge;
                    3'b110:  alu_d = AluBltu;
                    3'b111:  alu_d = AluBgeu;
                    default: illegal_d = 1'b1;
                endcase
            end
            7'b0000011: begin
                alu_d       = AluAdd;
                op2_imm_d   = 1'b1;
                imm_d       = imm_i;
                mem_read_d  = 1'b1;
                reg_write_d = 1'b1;
            end
            7'b0100011: begin
                alu_d       = AluAdd;
                op2_imm_d   = 1'b1;
                imm_d       = imm_s;
                mem_write_d = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase

        // An illegal encoding issues as a NOP with every side effect suppressed.
        if (illegal_d) begin
            alu_d       = AluNop;
            imm_d       = '0;
            op1_d       = Op1Rs1;
            op2_imm_d   = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end
        if (instr[11:7] == 5'd0) reg_write_d = 1'b0;
    end

    // FLUSH wins over STALL; an invalid slot while not stalled also becomes a bubble.
    assign bubble = FLUSH | (~STALL & ~INSTR_VALID_IN);

    // ID/EX register: reset/bubble clears, stall holds, otherwise load the decode.
    always_ff @(posedge CLK) begin
        if (RST || bubble) begin
            ALU_INSTRUCTION <= AluNop;
            IMM_OUT         <= '0;
            OP1_SEL         <= Op1Rs1;
            OP2_SEL_IMM     <= 1'b0;
            RS1_ADDR        <= '0;
            RS2_ADDR        <= '0;
            RD_ADDR         <= '0;
            REG_WRITE_EN    <= 1'b0;
            MEM_READ        <= 1'b0;
            MEM_WRITE       <= 1'b0;
            PC_OUT          <= '0;
            VALID_OUT       <= 1'b0;
            ILLEGAL_INSTR   <= 1'b0;
        end else if (!STALL) begin
            ALU_INSTRUCTION <= alu_d;
            IMM_OUT         <= DATA_WIDTH'($signed(imm_d));
            OP1_SEL         <= op1_d;
            OP2_SEL_IMM     <= op2_imm_d;
            RS1_ADDR        <= REG_ADDR_WIDTH'(instr[19:15]);
            RS2_ADDR        <= REG_ADDR_WIDTH'(instr[24:20]);
            RD_ADDR         <= REG_ADDR_WIDTH'(instr[11:7]);
            REG_WRITE_EN    <= reg_write_d;
            MEM_READ        <= mem_read_d;
            MEM_WRITE       <= mem_write_d;
            PC_OUT          <= PC_IN;
            VALID_OUT       <= 1'b1;
            ILLEGAL_INSTR   <= illegal_d;
        end
    end

endmodule

// File: doc/id_alu_decoder.md
Name: id_alu_decoder

Overview:
Instruction-decode stage register that produces the control word consumed by the execute-stage ALU. It takes a fetched RV32I instruction and its PC, decodes it into the 5-bit ALU operation code, operand selects, immediate, register addresses and write/memory enables, and registers them into the ID/EX pipeline. It supports a stall (hold) and a flush (bubble) from the hazard unit.

Parameters:
DATA_WIDTH, 32, instruction/PC/immediate width
REG_ADDR_WIDTH, 5, register-file address width

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
INSTR_IN  input  32  fetched instruction
PC_IN  input  32  PC of INSTR_IN
INSTR_VALID_IN  input  1  INSTR_IN/PC_IN valid this cycle
STALL  input  1  hold all outputs (EX not accepting)
FLUSH  input  1  insert bubble (branch taken / redirect)
ALU_INSTRUCTION  output  5  ALU op code (NOP=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10, SLLI=11, SRLI=12, SRAI=13, JAL=14, JALR=15, BEQ=16, BNE=17, BLT=18, BGE=19, BLTU=20, BGEU=21)
IMM_OUT  output  32  sign-extended immediate
OP1_SEL  output  2  0=rs1, 1=PC, 2=zero
OP2_SEL_IMM  output  1  1=immediate, 0=rs2
RS1_ADDR, RS2_ADDR, RD_ADDR  output  5 each  register addresses
REG_WRITE_EN  output  1  write rd in WB
MEM_READ, MEM_WRITE  output  1 each  load/store
PC_OUT  output  32  registered PC_IN
VALID_OUT  output  1  outputs hold a real instruction
ILLEGAL_INSTR  output  1  unsupported encoding decoded

Behaviour:
- One clock, synchronous active-high RST. Latency: 1 cycle, INSTR_IN sampled at edge N appears on outputs after edge N.
- Reset: all outputs 0 (ALU_INSTRUCTION=NOP, VALID_OUT=0, ILLEGAL_INSTR=0). RST mid-operation discards the held instruction at that edge.
- Priority per edge: RST > FLUSH > STALL > load.
- FLUSH=1: VALID_OUT<=0; ALU_INSTRUCTION<=NOP; REG_WRITE_EN, MEM_READ, MEM_WRITE, ILLEGAL_INSTR <=0; other fields don't-care (drive 0). FLUSH with STALL in the same cycle still flushes.
- STALL=1 (no FLUSH): every output register holds its value; INSTR_IN ignored.
- Load with INSTR_VALID_IN=0: bubble, same as FLUSH.
- Load with INSTR_VALID_IN=1: VALID_OUT<=1, decoded fields registered.
- Decode by opcode [6:0]:
  - 0110011 R-type: f3/f7 -> ADD/SUB(f7=0100000)/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; OP1=rs1, OP2=rs2, REG_WRITE.
  - 0010011 I-ALU: ADDI->ADD, SLTI->SLT, SLTIU->SLTU, XORI->XOR, ORI->OR, ANDI->AND; SLLI (f7=0)->SLLI, SRLI (f7=0)->SRLI, SRAI (f7=0100000)->SRAI; other f7 on shifts is illegal. IMM=I-imm; OP2=imm.
  - 0110111 LUI: ADD, OP1=zero, IMM=U-imm. 0010111 AUIPC: ADD, OP1=PC, IMM=U-imm.
  - 1101111 JAL: JAL, OP1=PC, IMM=J-imm, REG_WRITE. 1100111 (f3=0) JALR: JALR, OP1=rs1, IMM=I-imm, REG_WRITE.
  - 1100011 branches: f3 000/001/100/101/110/111 -> BEQ/BNE/BLT/BGE/BLTU/BGEU; OP2=rs2, IMM=B-imm, no REG_WRITE. f3 010/011 illegal.
  - 0000011 loads: ADD, IMM=I-imm, MEM_READ, REG_WRITE. 0100011 stores: ADD, IMM=S-imm, MEM_WRITE.
  - Other opcodes: illegal.
- Illegal: ALU_INSTRUCTION=NOP, all enables 0, ILLEGAL_INSTR=1, VALID_OUT=1.
- RD_ADDR=0 forces REG_WRITE_EN=0.
- Immediates are sign-extended from bit 31. B/J immediates have bit 0 = 0.

Test Plan:
- RST then INSTR_IN=0x00500093 (addi x1,x0,5), valid -> next cycle ALU_INSTRUCTION=1, IMM_OUT=5, OP2_SEL_IMM=1, OP1_SEL=0, RD_ADDR=1, REG_WRITE_EN=1, VALID_OUT=1.
- 0x402081B3 (sub x3,x1,x2) -> ALU_INSTRUCTION=2, RS1=1, RS2=2, RD=3, OP2_SEL_IMM=0; then 0x40335293 (srai x5,x6,3) -> ALU_INSTRUCTION=13, IMM_OUT[4:0]=3.
- 0xFE208CE3 (beq x1,x2,-8) -> ALU_INSTRUCTION=16, IMM_OUT=0xFFFFFFF8, REG_WRITE_EN=0; 0x0000006F (jal x0,0) -> ALU_INSTRUCTION=14, OP1_SEL=1, REG_WRITE_EN=0 (rd=x0).
- Load addi, then STALL=1 for 3 cycles while INSTR_IN changes -> outputs stay at addi values; assert FLUSH+STALL together -> next cycle VALID_OUT=0, ALU_INSTRUCTION=0.
- INSTR_IN=0xFFFFFFFF valid -> ILLEGAL_INSTR=1, ALU_INSTRUCTION=0, REG_WRITE_EN=0; next valid instruction clears ILLEGAL_INSTR.
- Valid instruction loaded, RST asserted one cycle -> all outputs 0 after that edge regardless of STALL.
